nanorv32_flow_ctrl_mi: RTL

NANORV32_FLOW_CTRL_MI -- requirements
Module: nanorv32_flow_ctrl_mi

---
 rtl/nanorv32_flow_ctrl_mi.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/nanorv32_flow_ctrl_mi.sv
// Pipeline flow control for nanorv32: stalls, branch PC select, data-access wait
// states, and micro-ROM driven interrupt entry/return sequences.
module nanorv32_flow_ctrl_mi #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned UROM_AW     = 6,
    parameter int unsigned ENTRY_START = 0,
    parameter int unsigned ENTRY_STOP  = 3,
    parameter int unsigned EXIT_START  = 8,
    parameter int unsigned EXIT_STOP   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_taken,
    input  logic               datamem_read,
    input  logic               datamem_write,
    input  logic               hreadyd,
    input  logic               codeif_cpu_ready_r,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               reti_inst_detected,
    output logic [3:0]         pstate_r,
    output logic               force_stall_pstate,
    output logic               force_stall_pstate2,
    output logic               force_stall_reset,
    output logic               output_new_pc,
    output logic               data_access_cycle,
    output logic               irq_ack,
    output logic [3:0]         irq_id,
    output logic               in_irq,
    output logic               irq_bypass_inst_reg,
    output logic [UROM_AW-1:0] urom_addr
);

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_CONT       = 4'd1,
        ST_BRANCH     = 4'd2,
        ST_WAITLD     = 4'd3,
        ST_IRQ_BEGIN  = 4'd4,
        ST_IRQ_CONT   = 4'd5,
        ST_IRQ_END    = 4'd6,
        ST_RETI_BEGIN = 4'd7,
        ST_RETI_CONT  = 4'd8,
        ST_RETI_END   = 4'd9
    } state_e;

    localparam logic [UROM_AW-1:0] ENTRY_START_A = UROM_AW'(ENTRY_START);
    localparam logic [UROM_AW-1:0] ENTRY_STOP_A  = UROM_AW'(ENTRY_STOP);
    localparam logic [UROM_AW-1:0] EXIT_START_A  = UROM_AW'(EXIT_START);
    localparam logic [UROM_AW-1:0] EXIT_STOP_A   = UROM_AW'(EXIT_STOP);

    state_e             pstate_q, pstate_d;
    logic [UROM_AW-1:0] urom_addr_q, urom_addr_d;
    logic [3:0]         irq_id_q, irq_id_d;
    logic               in_irq_q, in_irq_d;
    logic               bypass_q, bypass_d;

    logic               irq_pend, reti_q;
    logic [3:0]         irq_win;
    logic               irq_found;
    state_e             tail_next;

    assign irq_pend = (|irq) && !in_irq_q;
    assign reti_q   = reti_inst_detected && in_irq_q;

    // Common fall-through once nothing higher priority applies.
    assign tail_next = irq_pend ? ST_IRQ_BEGIN : (reti_q ? ST_RETI_BEGIN : ST_CONT);

    always_comb begin
        irq_win   = '0;
        irq_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq[i] && !irq_found) begin
                irq_win   = 4'(i);
                irq_found = 1'b1;
            end
        end
    end

    always_comb begin
        pstate_d            = pstate_q;
        urom_addr_d         = urom_addr_q;
        in_irq_d            = in_irq_q;
        irq_id_d            = irq_id_q;
        force_stall_pstate  = 1'b0;
        force_stall_pstate2 = 1'b0;
        force_stall_reset   = 1'b0;
        output_new_pc       = 1'b0;
        data_access_cycle   = 1'b0;
        irq_ack             = 1'b0;

        case (pstate_q)
            ST_RESET: begin
                force_stall_pstate  = 1'b1;
                force_stall_pstate2 = 1'b1;
                force_stall_reset   = 1'b1;
                pstate_d            = ST_CONT;
            end
            ST_CONT: begin
                if (branch_taken) begin
                    force_stall_pstate = 1'b1;
                    output_new_pc      = 1'b1;
                    pstate_d           = ST_BRANCH;
                end else if (datamem_read || datamem_write) begin
                    force_stall_pstate2 = 1'b1;
                    data_access_cycle   = 1'b1;
                    pstate_d            = ST_WAITLD;
                end else begin
                    pstate_d = tail_next;
                end
            end
            ST_BRANCH: begin
                output_new_pc = 1'b1;
                if (!codeif_cpu_ready_r) begin
                    force_stall_pstate = 1'b1;
                end else begin
                    pstate_d = tail_next;
                end
            end
            ST_WAITLD: begin
                // Back-to-back accesses take precedence over a branch here.
                if (!hreadyd) begin
                    force_stall_pstate  = 1'b1;
                    force_stall_pstate2 = 1'b1;
                end else if (datamem_read || datamem_write) begin
                    force_stall_pstate2 = 1'b1;
                    data_access_cycle   = 1'b1;
                end else if (branch_taken) begin
                    force_stall_pstate = 1'b1;
                    output_new_pc      = 1'b1;
                    pstate_d           = ST_BRANCH;
                end else begin
                    pstate_d = tail_next;
                end
            end
            ST_IRQ_BEGIN: begin
                irq_ack     = 1'b1;
                urom_addr_d = ENTRY_START_A;
                in_irq_d    = 1'b1;
                pstate_d    = ST_IRQ_CONT;
            end
            ST_IRQ_CONT: begin
                urom_addr_d = urom_addr_q + 1'b1;
                if (urom_addr_q == ENTRY_STOP_A) pstate_d = ST_IRQ_END;
            end
            ST_IRQ_END: pstate_d = ST_CONT;
            ST_RETI_BEGIN: begin
                urom_addr_d = EXIT_START_A;
                pstate_d    = ST_RETI_CONT;
            end
            ST_RETI_CONT: begin
                urom_addr_d = urom_addr_q + 1'b1;
                if (urom_addr_q == EXIT_STOP_A) pstate_d = ST_RETI_END;
            end
            ST_RETI_END: begin
                in_irq_d = 1'b0;
                pstate_d = ST_CONT;
            end
            default: pstate_d = ST_CONT;
        endcase

        if (pstate_d == ST_IRQ_BEGIN && pstate_q != ST_IRQ_BEGIN) irq_id_d = irq_win;
    end

    assign bypass_d = (pstate_q == ST_IRQ_BEGIN) || (pstate_q == ST_IRQ_CONT) ||
                      (pstate_q == ST_RETI_BEGIN) || (pstate_q == ST_RETI_CONT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q    <= ST_RESET;
            urom_addr_q <= '0;
            irq_id_q    <= '0;
            in_irq_q    <= 1'b0;
            bypass_q    <= 1'b0;
        end else begin
            pstate_q    <= pstate_d;
            urom_addr_q <= urom_addr_d;
            irq_id_q    <= irq_id_d;
            in_irq_q    <= in_irq_d;
            bypass_q    <= bypass_d;
        end
    end

    assign pstate_r            = pstate_q;
    assign urom_addr           = urom_addr_q;
    assign irq_id              = irq_id_q;
    assign in_irq              = in_irq_q;
    assign irq_bypass_inst_reg = bypass_q;

endmodule
